matmul_sequencer: RTL and testbench

//  Sequences one shared signed fixed-point MAC over C[M][N] = A[M][K] * B[K][N].
//  A, B and C live in external row-major RAMs with 1-cycle read latency.

---
 rtl/matmul_pkg.sv | 30 +++
 rtl/matmul_index_counter.sv | 75 +++++++
 rtl/matmul_sequencer.sv | 135 +++++++++++++
 tb/tb_matmul_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matrix-multiply sequencer.
// Imported by the top level and the index counter.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } seq_state_e;

    // Tag fields are sized for the largest supported dimension and zero-extended into place.
    localparam int IDX_MAX_W = 8;

    typedef struct packed {
        logic                 first;
        logic                 last;
        logic [IDX_MAX_W-1:0] i;
        logic [IDX_MAX_W-1:0] j;
    } mac_tag_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_w(input int data_w, input int k);
        return 2 * data_w + $clog2(k);
    endfunction

endpackage

// File: rtl/matmul_index_counter.sv
// Nested i/j/k loop counter, k innermost; wraps to zero only after the final element.
// Exposes first/last-of-reduction flags and a whole-product-complete flag.
module matmul_index_counter
    import matmul_pkg::*;
#(
    parameter int M = 2,
    parameter int K = 2,
    parameter int N = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                step_i,
    input  logic                clear_i,
    output logic [idx_w(M)-1:0] i_o,
    output logic [idx_w(N)-1:0] j_o,
    output logic [idx_w(K)-1:0] k_o,
    output logic                first_k_o,
    output logic                last_k_o,
    output logic                last_all_o
);

    localparam int IW = idx_w(M);
    localparam int JW = idx_w(N);
    localparam int KW = idx_w(K);

    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;
    logic          last_j;

    assign first_k_o  = (k_q == '0);
    assign last_k_o   = (k_q == KW'(K - 1));
    assign last_j     = (j_q == JW'(N - 1));
    assign last_all_o = last_k_o && last_j && (i_q == IW'(M - 1));

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        if (clear_i) begin
            i_d = '0;
            j_d = '0;
            k_d = '0;
        end else if (step_i) begin
            if (!last_k_o) begin
                k_d = k_q + 1'b1;
            end else begin
                k_d = '0;
                if (!last_j) begin
                    j_d = j_q + 1'b1;
                end else begin
                    j_d = '0;
                    i_d = last_all_o ? '0 : i_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
        end
    end

    assign i_o = i_q;
    assign j_o = j_q;
    assign k_o = k_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Drives one shared signed MAC over C = A * B using 1-cycle-latency row-major RAMs:
// issue stage (reads + tag), data stage (multiply-accumulate), registered C write.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int M      = 2,
    parameter int K      = 2,
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = acc_w(DATA_W, K)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    a_rd_en,
    output logic [idx_w(M*K)-1:0]   a_addr,
    input  logic [DATA_W-1:0]       a_data,
    output logic                    b_rd_en,
    output logic [idx_w(K*N)-1:0]   b_addr,
    input  logic [DATA_W-1:0]       b_data,
    output logic                    c_wr_en,
    output logic [idx_w(M*N)-1:0]   c_addr,
    output logic [ACC_W-1:0]        c_data
);

    localparam int AW = idx_w(M * K);
    localparam int BW = idx_w(K * N);
    localparam int CW = idx_w(M * N);
    localparam int PW = 2 * DATA_W;

    seq_state_e state_q;

    logic [idx_w(M)-1:0] i_cnt;
    logic [idx_w(N)-1:0] j_cnt;
    logic [idx_w(K)-1:0] k_cnt;
    logic                first_k, last_k, last_all;
    logic                issue;

    mac_tag_t tag_d, tag_q;
    logic     pv_q;

    logic signed [PW-1:0]    a_s, b_s, prod;
    logic signed [ACC_W-1:0] prod_ext, acc_d, acc_q;

    logic                    c_wr_en_q;
    logic [CW-1:0]           c_addr_q;
    logic [ACC_W-1:0]        c_data_q;

    assign issue = (state_q == RUN);

    matmul_index_counter #(.M(M), .K(K), .N(N)) u_idx (
        .clk_i      (clk),
        .rst_i      (rst),
        .step_i     (issue),
        .clear_i    (state_q == IDLE),
        .i_o        (i_cnt),
        .j_o        (j_cnt),
        .k_o        (k_cnt),
        .first_k_o  (first_k),
        .last_k_o   (last_k),
        .last_all_o (last_all)
    );

    // DRAIN waits for the data stage to empty; by then the final write is in c_wr_en_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_q <= RUN;
                RUN:     if (last_all) state_q <= DRAIN;
                DRAIN:   if (!pv_q) state_q <= FIN;
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q == RUN) || (state_q == DRAIN);
    assign done    = (state_q == FIN);
    assign a_rd_en = issue;
    assign b_rd_en = issue;
    assign a_addr  = AW'(int'(i_cnt) * K + int'(k_cnt));
    assign b_addr  = BW'(int'(k_cnt) * N + int'(j_cnt));

    always_comb begin
        tag_d       = '0;
        tag_d.first = first_k;
        tag_d.last  = last_k;
        tag_d.i     = IDX_MAX_W'(i_cnt);
        tag_d.j     = IDX_MAX_W'(j_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q  <= 1'b0;
            tag_q <= '0;
        end else begin
            pv_q  <= issue;
            tag_q <= tag_d;
        end
    end

    assign a_s      = PW'($signed(a_data));
    assign b_s      = PW'($signed(b_data));
    assign prod     = a_s * b_s;
    assign prod_ext = ACC_W'(prod);
    assign acc_d    = tag_q.first ? prod_ext : acc_q + prod_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            c_wr_en_q <= 1'b0;
            c_addr_q  <= '0;
            c_data_q  <= '0;
        end else begin
            c_wr_en_q <= 1'b0;
            if (pv_q) begin
                acc_q <= acc_d;
                if (tag_q.last) begin
                    c_wr_en_q <= 1'b1;
                    c_addr_q  <= CW'(int'(tag_q.i) * N + int'(tag_q.j));
                    c_data_q  <= acc_d;
                end
            end
        end
    end

    assign c_wr_en = c_wr_en_q;
    assign c_addr  = c_addr_q;
    assign c_data  = c_data_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench: a 2x3x2 sequencer against hand-computed products and timing,
// plus a 1x1x1 instance for the degenerate case.
module tb_matmul_sequencer;

    localparam int M     = 2;
    localparam int K     = 3;
    localparam int N     = 2;
    localparam int DW    = 8;
    localparam int ACC_W = 18;

    logic clk = 1'b0;
    logic rst, start, start1;
    always #5 clk = ~clk;

    logic          busy, done, a_rd_en, b_rd_en, c_wr_en;
    logic [2:0]    a_addr, b_addr;
    logic [1:0]    c_addr;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic [ACC_W-1:0] c_data;

    logic          busy1, done1, a_rd_en1, b_rd_en1, c_wr_en1;
    logic [0:0]    a_addr1, b_addr1, c_addr1;
    logic [DW-1:0] a_data1 = '0, b_data1 = '0;
    logic [15:0]   c_data1;

    matmul_sequencer #(.M(M), .K(K), .N(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_data(a_data),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_data(b_data),
        .c_wr_en(c_wr_en), .c_addr(c_addr), .c_data(c_data)
    );

    matmul_sequencer #(.M(1), .K(1), .N(1), .DATA_W(DW)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .a_rd_en(a_rd_en1), .a_addr(a_addr1), .a_data(a_data1),
        .b_rd_en(b_rd_en1), .b_addr(b_addr1), .b_data(b_data1),
        .c_wr_en(c_wr_en1), .c_addr(c_addr1), .c_data(c_data1)
    );

    logic [DW-1:0] a_mem [M*K];
    logic [DW-1:0] b_mem [K*N];
    logic [DW-1:0] a1_val, b1_val;

    always @(posedge clk) begin
        if (a_rd_en)  a_data  <= a_mem[a_addr];
        if (b_rd_en)  b_data  <= b_mem[b_addr];
        if (a_rd_en1) a_data1 <= a1_val;
        if (b_rd_en1) b_data1 <= b1_val;
    end

    int n_asrt = 0;
    int n_fail = 0;
    int cur_n  = 0;
    logic signed [31:0] exp_c [4];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0d required %0d", tag, cur_n, obs, exp);
        end
    endtask

    task automatic load_test1();
        a_mem = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        b_mem = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
        exp_c = '{58, 64, 139, 154};
    endtask

    task automatic load_const(input logic [DW-1:0] av, input logic [DW-1:0] bv, input int c);
        for (int x = 0; x < M*K; x++) a_mem[x] = av;
        for (int x = 0; x < K*N; x++) b_mem[x] = bv;
        for (int x = 0; x < 4; x++) exp_c[x] = c;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_a_rd_en"}, a_rd_en, 0);
        chk({tag, "_b_rd_en"}, b_rd_en, 0);
        chk({tag, "_a_addr"}, a_addr, 0);
        chk({tag, "_b_addr"}, b_addr, 0);
        chk({tag, "_c_wr_en"}, c_wr_en, 0);
        chk({tag, "_c_addr"}, c_addr, 0);
        chk({tag, "_c_data"}, $signed(c_data), 0);
    endtask

    // Entered mid cycle c0 with start already high; checks cycles c0+1 .. c0+15+tail.
    task automatic run_check(input bit hold, input int pa, input int pb, input int tail);
        int  r;
        bit  rd, wr;
        for (int n = 1; n <= 15 + tail; n++) begin
            @(negedge clk);
            cur_n = n;
            r  = n - 1;
            rd = (n <= 12);
            wr = (n >= 5) && (n <= 14) && ((n - 5) % 3 == 0);
            chk("busy", busy, (n <= 14));
            chk("done", done, (n == 15));
            chk("a_rd_en", a_rd_en, rd);
            chk("b_rd_en", b_rd_en, rd);
            if (rd) begin
                chk("a_addr", a_addr, (r / 6) * 3 + r % 3);
                chk("b_addr", b_addr, (r % 3) * 2 + (r / 3) % 2);
            end
            chk("c_wr_en", c_wr_en, wr);
            if (wr) begin
                chk("c_addr", c_addr, (n - 5) / 3);
                chk("c_data", $signed(c_data), exp_c[(n - 5) / 3]);
            end
            start = hold || (n == pa) || (n == pb);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start1 = 1'b0;
        a1_val = '0;
        b1_val = '0;
        load_test1();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        chk("reset_busy1", busy1, 0);
        chk("reset_c_wr_en1", c_wr_en1, 0);
        chk("reset_done1", done1, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic product with timing.
        start = 1'b1;
        run_check(1'b0, 0, 0, 2);

        // Signed extremes.
        load_const(8'h80, 8'h80, 49152);
        start = 1'b1;
        run_check(1'b0, 0, 0, 1);
        load_const(8'h80, 8'h7f, -48768);
        start = 1'b1;
        run_check(1'b0, 0, 0, 1);

        // Reset mid-run abandons the product.
        load_test1();
        start = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            cur_n = n;
            start = 1'b0;
            chk("mid_busy", busy, 1);
            if (n == 5) begin
                chk("mid_c_wr_en", c_wr_en, 1);
                chk("mid_c_data", $signed(c_data), 58);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        cur_n = 7;
        chk_all_zero("midrst");
        rst = 1'b0;
        for (int n = 8; n < 20; n++) begin
            @(negedge clk);
            cur_n = n;
            chk("post_rst_c_wr_en", c_wr_en, 0);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        start = 1'b1;
        run_check(1'b0, 0, 0, 2);

        // start while busy and during FIN is ignored.
        start = 1'b1;
        run_check(1'b0, 3, 15, 3);

        // start held high: back-to-back runs with one IDLE cycle between.
        start = 1'b1;
        run_check(1'b1, 0, 0, 0);
        @(negedge clk);
        cur_n = 16;
        chk("b2b_idle_busy", busy, 0);
        chk("b2b_idle_done", done, 0);
        chk("b2b_idle_rd", a_rd_en, 0);
        run_check(1'b1, 0, 0, 0);
        @(negedge clk);
        cur_n = 16;
        chk("b2b_end_busy", busy, 0);
        start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            cur_n++;
            chk("b2b_stop_busy", busy, 0);
            chk("b2b_stop_rd", a_rd_en, 0);
        end

        // Degenerate 1x1x1 product.
        a1_val = 8'hfd;
        b1_val = 8'd5;
        start1 = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            cur_n  = n;
            start1 = 1'b0;
            chk("u1_a_rd_en", a_rd_en1, (n == 1));
            chk("u1_b_rd_en", b_rd_en1, (n == 1));
            chk("u1_busy", busy1, (n <= 3));
            chk("u1_c_wr_en", c_wr_en1, (n == 3));
            chk("u1_done", done1, (n == 4));
            if (n == 3) begin
                chk("u1_c_data", $signed(c_data1), -15);
                chk("u1_c_addr", c_addr1, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
